gpu_fb_writer: RTL

- Pixel-stream sink for the GPU_top output interface (output_valid/draw/pixel_x_out/pixel_y_out/output_color/frame_end/out_ready).
- Converts (x,y,color) beats into linear framebuffer write transactions.
- Buffers them in a small FIFO against a stallable memory write port.
- Generates out_ready backpressure and signals frame completion to the controller.

---
 rtl/gpu_fb_writer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/gpu_fb_writer.sv
// Pixel-stream sink: turns (x,y,color) beats into linear framebuffer writes through a FWFT FIFO.
// Optional framebuffer clear before each frame is compiled in with `define GPU_FB_CLEAR_EN.
module gpu_fb_writer #(
  parameter int H_RES      = 800,
  parameter int V_RES      = 600,
  parameter int COLOR_W    = 8,
  parameter int COORD_W    = 11,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = $clog2(H_RES*V_RES),
  parameter logic [COLOR_W-1:0] CLEAR_COLOR = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               in_valid,
  input  logic               in_draw,
  input  logic [COORD_W-1:0] in_x,
  input  logic [COORD_W-1:0] in_y,
  input  logic [COLOR_W-1:0] in_color,
  input  logic               in_frame_end,
  output logic               in_ready,
  output logic               fb_wr_en,
  output logic [ADDR_W-1:0]  fb_wr_addr,
  output logic [COLOR_W-1:0] fb_wr_data,
  input  logic               fb_wr_ready,
  output logic               busy,
  output logic               frame_done,
  output logic [15:0]        drop_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]   DEPTH_L = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [COORD_W-1:0] H_LIM = COORD_W'(H_RES);
  localparam logic [COORD_W-1:0] V_LIM = COORD_W'(V_RES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACTIVE,
    S_DRAIN,
    S_DONE
`ifdef GPU_FB_CLEAR_EN
    , S_CLEAR
`endif
  } state_t;

  state_t state, state_nxt;

  logic                 stg_valid;
  logic [ADDR_W-1:0]    stg_addr;
  logic [COLOR_W-1:0]   stg_color;

  logic [ADDR_W+COLOR_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [PTR_W:0]       count;
  logic [PTR_W:0]       occ;
  logic                 fifo_ne, push, pop;
  logic                 accept, in_range, load, oor;
  logic                 drained_next;

  assign occ      = count + (PTR_W+1)'(stg_valid);
  assign in_ready = (state == S_ACTIVE) && (occ < DEPTH_L);
  assign accept   = in_valid && in_ready;
  assign in_range = (in_x < H_LIM) && (in_y < V_LIM);
  assign load     = accept && in_draw && in_range;
  assign oor      = accept && in_draw && !in_range;

  assign fifo_ne  = (count != '0);
  assign push     = stg_valid;
  assign pop      = fifo_ne && fb_wr_ready;

  // Lookahead so frame_done lands the cycle right after the final write handshake.
  assign drained_next = !stg_valid &&
                        ((count == '0) || ((count == (PTR_W+1)'(1)) && pop));

  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stg_valid <= 1'b0;
      stg_addr  <= '0;
      stg_color <= '0;
    end else begin
      stg_valid <= load;
      if (load) begin
        stg_addr  <= ADDR_W'(in_y) * ADDR_W'(H_RES) + ADDR_W'(in_x);
        stg_color <= in_color;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {stg_addr, stg_color};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_count <= '0;
    end else if (state == S_IDLE && start) begin
      drop_count <= '0;
    end else if (oor && drop_count != '1) begin
      drop_count <= drop_count + 16'd1;
    end
  end

`ifdef GPU_FB_CLEAR_EN
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(H_RES*V_RES - 1);
  logic [ADDR_W-1:0] clr_addr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clr_addr <= '0;
    end else if (state == S_IDLE && start) begin
      clr_addr <= '0;
    end else if (state == S_CLEAR && fb_wr_ready) begin
      clr_addr <= clr_addr + 1'b1;
    end
  end
`endif

  always_comb begin
    {fb_wr_addr, fb_wr_data} = fifo_ne ? mem[rd_ptr] : '0;
    fb_wr_en = fifo_ne;
`ifdef GPU_FB_CLEAR_EN
    if (state == S_CLEAR) begin
      fb_wr_en   = 1'b1;
      fb_wr_addr = clr_addr;
      fb_wr_data = CLEAR_COLOR;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
`ifdef GPU_FB_CLEAR_EN
          state_nxt = S_CLEAR;
`else
          state_nxt = S_ACTIVE;
`endif
        end
      end
`ifdef GPU_FB_CLEAR_EN
      S_CLEAR:  if (fb_wr_ready && clr_addr == CLR_LAST) state_nxt = S_ACTIVE;
`endif
      S_ACTIVE: if (in_frame_end) state_nxt = S_DRAIN;
      S_DRAIN:  if (drained_next) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

endmodule
